sram_phy: RTL

Pin-level asynchronous SRAM controller behind the supervisor/CPC memory multiplexer. It accepts single-word commands over the go/cmd/busy/valid handshake and drives an external 16-bit async SRAM with programmable read/write wait states and bus turnaround. It returns read data and completion pulses to the upstream stage. It owns every SRAM pin; nothing else in the design touches them.

---
 rtl/sram_phy.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_phy.sv
// sram_phy: pin-level controller for an external 16-bit asynchronous SRAM.
// Accepts single-word read/write commands over go/cmd/busy/valid. Read and
// write wait states and the bus turnaround gap are set by parameters.
// Optional feature macro SRAM_PHY_GO_QUEUE_EN: a one-deep pending register
// holds a go that arrives while busy and issues it when IDLE is reached.
// Handshake: mem_go_i is a one-cycle strobe sampled only when the controller
// can take it; mem_busy_o is high from the cycle after acceptance until the
// controller is idle again; mem_valid_o pulses once per completed command,
// and in that cycle mem_D_o holds the word just read.
module sram_phy #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [23:0]       mem_A_i,
    input  logic [15:0]       mem_D_i,
    input  logic              mem_go_i,
    input  logic [2:0]        mem_cmd_i,
    output logic [15:0]       mem_D_o,
    output logic              mem_busy_o,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] sram_A_o,
    output logic [15:0]       sram_D_o,
    input  logic [15:0]       sram_D_i,
    output logic              sram_D_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD, ST_DONE, ST_TURN
    } state_t;

    localparam logic [3:0] RD_LOAD   = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD   = 4'(WR_WAIT - 1);
    localparam logic [3:0] TURN_LOAD = 4'(TURN - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_src_addr;
    logic [15:0]       r_wdata, w_wdata_nxt, w_src_wdata;
    logic [2:0]        r_cmd, w_cmd_nxt, w_src_cmd;
    logic              w_start;
    logic              w_pend_nxt;
    logic              w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n, w_doe, w_valid;
    logic [ADDR_W-1:0] w_a;
    logic [15:0]       w_d;
    logic              w_unused;

    // Address bits above the SRAM width are don't-care.
    assign w_unused    = ^mem_A_i[23:ADDR_W];
    assign dbg_state_o = r_state;

`ifdef SRAM_PHY_GO_QUEUE_EN
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [15:0]       r_pend_wdata;
    logic [2:0]        r_pend_cmd;
    logic              w_pend_load;

    // A held command takes priority over a fresh go when IDLE is entered; a
    // go in that same cycle refills the pending slot it just vacated.
    assign w_start     = (r_state == ST_IDLE) && (r_pend || mem_go_i);
    assign w_src_addr  = r_pend ? r_pend_addr  : mem_A_i[ADDR_W-1:0];
    assign w_src_wdata = r_pend ? r_pend_wdata : mem_D_i;
    assign w_src_cmd   = r_pend ? r_pend_cmd   : mem_cmd_i;
    assign w_pend_load = mem_go_i && ((r_state != ST_IDLE) ? !r_pend : r_pend);
    assign w_pend_nxt  = w_pend_load || (r_pend && (r_state != ST_IDLE));

    // Pending command slot.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pend       <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
            r_pend_cmd   <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_pend_load) begin
                r_pend_addr  <= mem_A_i[ADDR_W-1:0];
                r_pend_wdata <= mem_D_i;
                r_pend_cmd   <= mem_cmd_i;
            end
        end
    end
`else
    // Gos outside IDLE are simply ignored.
    assign w_start     = (r_state == ST_IDLE) && mem_go_i;
    assign w_src_addr  = mem_A_i[ADDR_W-1:0];
    assign w_src_wdata = mem_D_i;
    assign w_src_cmd   = mem_cmd_i;
    assign w_pend_nxt  = 1'b0;
`endif

    assign w_addr_nxt  = w_start ? w_src_addr  : r_addr;
    assign w_wdata_nxt = w_start ? w_src_wdata : r_wdata;
    assign w_cmd_nxt   = w_start ? w_src_cmd   : r_cmd;

    // Next-state and wait-state counter sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_src_cmd[1] ? ST_RD : ST_WR_SETUP;
                    w_cnt_nxt   = RD_LOAD;
                end
            end
            ST_RD: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            ST_WR_SETUP: begin
                w_state_nxt = ST_WR_PULSE;
                w_cnt_nxt   = WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_WR_HOLD;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            ST_WR_HOLD: w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (TURN == 0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_TURN;
                    w_cnt_nxt   = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pin values for the state being entered, so every pin is a flop output.
    always_comb begin
        w_ce_n  = 1'b1;
        w_oe_n  = 1'b1;
        w_we_n  = 1'b1;
        w_ub_n  = 1'b1;
        w_lb_n  = 1'b1;
        w_doe   = 1'b0;
        w_valid = 1'b0;
        w_a     = sram_A_o;
        w_d     = sram_D_o;
        case (w_state_nxt)
            ST_RD: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
                w_ub_n = 1'b0;
                w_lb_n = 1'b0;
                w_a    = w_addr_nxt;
            end
            ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
                w_ce_n = 1'b0;
                w_doe  = 1'b1;
                w_a    = w_addr_nxt;
                w_d    = w_wdata_nxt;
                w_ub_n = ~(w_cmd_nxt[2] | w_cmd_nxt[0]);
                w_lb_n = ~(w_cmd_nxt[2] | ~w_cmd_nxt[0]);
                w_we_n = (w_state_nxt != ST_WR_PULSE);
            end
            ST_DONE: w_valid = 1'b1;
            default: ;
        endcase
    end

    // State, command latch, pin registers and read capture.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cmd       <= '0;
            mem_D_o     <= '0;
            mem_busy_o  <= 1'b0;
            mem_valid_o <= 1'b0;
            sram_A_o    <= '0;
            sram_D_o    <= '0;
            sram_D_oe_o <= 1'b0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_ub_n_o <= 1'b1;
            sram_lb_n_o <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_cmd       <= w_cmd_nxt;
            mem_busy_o  <= (w_state_nxt != ST_IDLE) || w_pend_nxt;
            mem_valid_o <= w_valid;
            sram_A_o    <= w_a;
            sram_D_o    <= w_d;
            sram_D_oe_o <= w_doe;
            sram_ce_n_o <= w_ce_n;
            sram_oe_n_o <= w_oe_n;
            sram_we_n_o <= w_we_n;
            sram_ub_n_o <= w_ub_n;
            sram_lb_n_o <= w_lb_n;
            if (r_state == ST_RD && r_cnt == 4'd0) mem_D_o <= sram_D_i;
        end
    end

endmodule
